// File: rtl/cpu_dbg_ahb_bridge.sv
// AHB-Lite debug/loader slave: word accesses to CPU IM/DM/RF peek ports plus RUN/CYCLES control.
// Latency: writes zero-wait (1 data cycle); reads one wait state (data 2 cycles after address phase).
// Backpressure: hreadyout low in RD_WAIT and ERR1 only; new address phases accepted while hreadyout=1.
module cpu_dbg_ahb_bridge #(
    parameter int IM_AW = 11,
    parameter int DM_AW = 11
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                hsel,
    input  logic [31:0]         haddr,
    input  logic [1:0]          htrans,
    input  logic                hwrite,
    input  logic [2:0]          hsize,
    input  logic [31:0]         hwdata,
    input  logic                hready,
    output logic                hreadyout,
    output logic                hresp,
    output logic [31:0]         hrdata,
    output logic                cpu_rstn,
    output logic [4:0]          ahb_rf_addr,
    input  logic [31:0]         ahb_rf_data,
    output logic [IM_AW-1:0]    ahb_im_addr,
    output logic [31:0]         ahb_im_din,
    output logic                ahb_im_wen,
    input  logic [31:0]         ahb_im_dout,
    output logic [DM_AW-1:0]    ahb_dm_addr,
    output logic [31:0]         ahb_dm_din,
    output logic                ahb_dm_wen,
    input  logic [31:0]         ahb_dm_dout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_WAIT = 3'd2,
        RD_DATA = 3'd3,
        ERR1    = 3'd4,
        ERR2    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        R_IM   = 2'b00,
        R_DM   = 2'b01,
        R_RF   = 2'b10,
        R_CTRL = 2'b11
    } region_t;

    state_t             state_q, state_d;
    region_t            region_q, region_d;
    logic               ctrl_off_q, ctrl_off_d;
    logic               run_q, run_d;
    logic               cpu_rstn_q, cpu_rstn_d;
    logic [31:0]        cycles_q, cycles_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [IM_AW-1:0]   im_addr_q, im_addr_d;
    logic [DM_AW-1:0]   dm_addr_q, dm_addr_d;
    logic [4:0]         rf_addr_q, rf_addr_d;

    logic               data_ready;
    logic               accept;
    region_t            a_region;
    logic               a_err;
    logic               wr_im, wr_dm, wr_run;
    logic               unused_ok;

    assign unused_ok = ^{haddr[31:16], htrans[0]};

    always_comb begin
        data_ready = (state_q == IDLE) || (state_q == WR) ||
                     (state_q == RD_DATA) || (state_q == ERR2);
        accept     = hsel && htrans[1] && hready && data_ready;
        a_region   = region_t'(haddr[15:14]);
        a_err      = (hsize != 3'b010) || (haddr[1:0] != 2'b00) ||
                     ((a_region == R_RF) && hwrite) ||
                     ((a_region == R_CTRL) && ((haddr[13:3] != '0) || (hwrite && haddr[2]))) ||
                     ((a_region == R_IM) && hwrite && run_q);
    end

    always_comb begin
        wr_im  = (state_q == WR) && (region_q == R_IM);
        wr_dm  = (state_q == WR) && (region_q == R_DM);
        wr_run = (state_q == WR) && (region_q == R_CTRL) && !ctrl_off_q;
    end

    // Next state; index registers only move for error-free accepted phases so errors leave no trace.
    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        ctrl_off_d = ctrl_off_q;
        im_addr_d  = im_addr_q;
        dm_addr_d  = dm_addr_q;
        rf_addr_d  = rf_addr_q;
        case (state_q)
            RD_WAIT: state_d = RD_DATA;
            ERR1:    state_d = ERR2;
            default: begin
                state_d = IDLE;
                if (accept) begin
                    if (a_err) begin
                        state_d = ERR1;
                    end else begin
                        state_d    = hwrite ? WR : RD_WAIT;
                        region_d   = a_region;
                        ctrl_off_d = haddr[2];
                        case (a_region)
                            R_IM:    im_addr_d = haddr[IM_AW+1:2];
                            R_DM:    dm_addr_d = haddr[DM_AW+1:2];
                            R_RF:    rf_addr_d = haddr[6:2];
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    always_comb begin
        run_d      = run_q;
        cpu_rstn_d = run_q;
        cycles_d   = run_q ? (cycles_q + 32'd1) : cycles_q;
        rdata_d    = rdata_q;
        if (wr_run) begin
            run_d = hwdata[0];
            if (hwdata[0] && !run_q) begin
                cycles_d = '0;
            end
        end
        // Capture at the end of RD_WAIT; memory dout is valid for the index presented this cycle.
        if (state_q == RD_WAIT) begin
            case (region_q)
                R_IM:    rdata_d = ahb_im_dout;
                R_DM:    rdata_d = ahb_dm_dout;
                R_RF:    rdata_d = ahb_rf_data;
                default: rdata_d = ctrl_off_q ? cycles_q : {31'd0, run_q};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            region_q   <= R_IM;
            ctrl_off_q <= 1'b0;
            run_q      <= 1'b0;
            cpu_rstn_q <= 1'b0;
            cycles_q   <= '0;
            rdata_q    <= '0;
            im_addr_q  <= '0;
            dm_addr_q  <= '0;
            rf_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            ctrl_off_q <= ctrl_off_d;
            run_q      <= run_d;
            cpu_rstn_q <= cpu_rstn_d;
            cycles_q   <= cycles_d;
            rdata_q    <= rdata_d;
            im_addr_q  <= im_addr_d;
            dm_addr_q  <= dm_addr_d;
            rf_addr_q  <= rf_addr_d;
        end
    end

    always_comb begin
        hreadyout   = !((state_q == RD_WAIT) || (state_q == ERR1));
        hresp       = (state_q == ERR1) || (state_q == ERR2);
        hrdata      = rdata_q;
        cpu_rstn    = cpu_rstn_q;
        ahb_im_addr = im_addr_q;
        ahb_dm_addr = dm_addr_q;
        ahb_rf_addr = rf_addr_q;
        ahb_im_wen  = wr_im;
        ahb_dm_wen  = wr_dm;
        ahb_im_din  = wr_im ? hwdata : '0;
        ahb_dm_din  = wr_dm ? hwdata : '0;
    end

endmodule

// File: tb/tb_cpu_dbg_ahb_bridge.sv
// Bench for cpu_dbg_ahb_bridge: vector table through a bus task with a scoreboard queue,
// plus hand sequences for CYCLES timing, back-to-back write/read and mid-transfer reset.
module tb_cpu_dbg_ahb_bridge;

    logic        clk;
    logic        rstn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        cpu_rstn;
    logic [4:0]  ahb_rf_addr;
    logic [31:0] ahb_rf_data;
    logic [10:0] ahb_im_addr;
    logic [31:0] ahb_im_din;
    logic        ahb_im_wen;
    logic [31:0] ahb_im_dout;
    logic [10:0] ahb_dm_addr;
    logic [31:0] ahb_dm_din;
    logic        ahb_dm_wen;
    logic [31:0] ahb_dm_dout;

    cpu_dbg_ahb_bridge #(.IM_AW(11), .DM_AW(11)) dut (
        .clk(clk), .rstn(rstn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .cpu_rstn(cpu_rstn),
        .ahb_rf_addr(ahb_rf_addr), .ahb_rf_data(ahb_rf_data),
        .ahb_im_addr(ahb_im_addr), .ahb_im_din(ahb_im_din), .ahb_im_wen(ahb_im_wen),
        .ahb_im_dout(ahb_im_dout),
        .ahb_dm_addr(ahb_dm_addr), .ahb_dm_din(ahb_dm_din), .ahb_dm_wen(ahb_dm_wen),
        .ahb_dm_dout(ahb_dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-slave bus: the global ready is the slave's own ready.
    assign hready = hreadyout;

    // Memories with combinational read of the presented index.
    logic [31:0] im_mem [0:2047];
    logic [31:0] dm_mem [0:2047];
    assign ahb_im_dout = im_mem[ahb_im_addr];
    assign ahb_dm_dout = dm_mem[ahb_dm_addr];

    int          im_wen_cnt = 0;
    int          dm_wen_cnt = 0;
    logic [10:0] im_wlast_addr = '0;
    always @(posedge clk) begin
        if (ahb_im_wen) begin
            im_mem[ahb_im_addr] <= ahb_im_din;
            im_wen_cnt          <= im_wen_cnt + 1;
            im_wlast_addr       <= ahb_im_addr;
        end
        if (ahb_dm_wen) begin
            dm_mem[ahb_dm_addr] <= ahb_dm_din;
            dm_wen_cnt          <= dm_wen_cnt + 1;
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        resp;
        int          waits;
        int          im_w;
        int          dm_w;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        resp;
        int          waits;
        logic        chk_rd;
    } exp_t;

    vec_t vecs [13];
    exp_t sb_q [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // One non-pipelined transfer: address phase, then data phase until hreadyout (bounded).
    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic rsp_first, output logic rsp_last, output int waits);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hwdata = wd;
        waits = -1; rd = '0; rsp_first = 1'b0; rsp_last = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) rsp_first = hresp;
            if (hreadyout) begin
                waits = i; rsp_last = hresp; rd = hrdata;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    // Push expectation, run transfer, pop and compare.
    task automatic sb_xfer(input string name, input logic [31:0] a, input logic w,
                           input logic [2:0] sz, input logic [31:0] wd,
                           input logic [31:0] erd, input logic ersp, input int ewaits);
        logic [31:0] rd;
        logic        rf, rl;
        int          wt;
        exp_t        e;
        sb_q.push_back('{erd, ersp, ewaits, (!w && !ersp)});
        xfer(a, w, sz, wd, rd, rf, rl, wt);
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_waits"}, wt, e.waits);
            chk({name, "_resp1"}, {31'd0, rf}, {31'd0, e.resp});
            chk({name, "_resp2"}, {31'd0, rl}, {31'd0, e.resp});
            if (e.chk_rd) chk({name, "_rdata"}, rd, e.rdata);
        end
    endtask

    initial begin
        int im0, dm0;

        vecs[0]  = '{32'h0000_0014, 1'b1, 3'b010, 32'h1234_5678, 32'h0,         1'b0, 0, 1, 0};
        vecs[1]  = '{32'h0000_0014, 1'b0, 3'b010, 32'h0,         32'h1234_5678, 1'b0, 1, 0, 0};
        vecs[2]  = '{32'h0000_4008, 1'b1, 3'b010, 32'hA5A5_0001, 32'h0,         1'b0, 0, 0, 1};
        vecs[3]  = '{32'h0000_4008, 1'b0, 3'b010, 32'h0,         32'hA5A5_0001, 1'b0, 1, 0, 0};
        vecs[4]  = '{32'h0000_807C, 1'b0, 3'b010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1, 0, 0};
        vecs[5]  = '{32'h0000_807C, 1'b1, 3'b010, 32'h1111_1111, 32'h0,         1'b1, 1, 0, 0};
        vecs[6]  = '{32'h0000_0014, 1'b0, 3'b000, 32'h0,         32'h0,         1'b1, 1, 0, 0};
        vecs[7]  = '{32'h0000_0002, 1'b0, 3'b010, 32'h0,         32'h0,         1'b1, 1, 0, 0};
        vecs[8]  = '{32'h0000_C008, 1'b0, 3'b010, 32'h0,         32'h0,         1'b1, 1, 0, 0};
        vecs[9]  = '{32'h0000_C004, 1'b1, 3'b010, 32'h0000_0055, 32'h0,         1'b1, 1, 0, 0};
        vecs[10] = '{32'h0000_C000, 1'b0, 3'b010, 32'h0,         32'h0,         1'b0, 1, 0, 0};
        vecs[11] = '{32'h0000_C004, 1'b0, 3'b010, 32'h0,         32'h0,         1'b0, 1, 0, 0};
        vecs[12] = '{32'h0000_0020, 1'b1, 3'b001, 32'h0BAD_F00D, 32'h0,         1'b1, 1, 0, 0};

        rstn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'b010; hwdata = '0; ahb_rf_data = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
        chk("rst_hresp", {31'd0, hresp}, 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
        chk("rst_wen", {30'd0, ahb_im_wen, ahb_dm_wen}, 32'd0);
        chk("rst_addrs", {ahb_rf_addr, ahb_im_addr, ahb_dm_addr}, 32'd0);
        chk("rst_din", ahb_im_din | ahb_dm_din, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            im0 = im_wen_cnt; dm0 = dm_wen_cnt;
            sb_xfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].size,
                    vecs[i].wdata, vecs[i].rdata, vecs[i].resp, vecs[i].waits);
            chk($sformatf("vec%0d_im_wen", i), im_wen_cnt - im0, vecs[i].im_w);
            chk($sformatf("vec%0d_dm_wen", i), dm_wen_cnt - dm0, vecs[i].dm_w);
            if (i == 0) chk("im_write_addr", {21'd0, im_wlast_addr}, 32'd5);
            if (i == 4) chk("rf_addr", {27'd0, ahb_rf_addr}, 32'd31);
        end

        // RUN set: cpu_rstn follows one cycle after RUN; CYCLES restarts at 0 after the WR edge.
        sb_xfer("run_set", 32'h0000_C000, 1'b1, 3'b010, 32'h1, 32'h0, 1'b0, 0);
        chk("cpu_rstn_lag", {31'd0, cpu_rstn}, 32'd0);
        @(posedge clk); #1;
        chk("cpu_rstn_rise", {31'd0, cpu_rstn}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        // 11 increments so far, one more at the end of the address phase, captured at end of RD_WAIT.
        sb_xfer("cycles", 32'h0000_C004, 1'b0, 3'b010, 32'h0, 32'd12, 1'b0, 1);
        sb_xfer("run_rd", 32'h0000_C000, 1'b0, 3'b010, 32'h0, 32'd1, 1'b0, 1);

        im0 = im_wen_cnt; dm0 = dm_wen_cnt;
        sb_xfer("im_wr_running", 32'h0000_0000, 1'b1, 3'b010, 32'h7777_7777, 32'h0, 1'b1, 1);
        chk("im_wr_running_wen", im_wen_cnt - im0, 32'd0);
        sb_xfer("dm_wr_running", 32'h0000_4008, 1'b1, 3'b010, 32'h0000_BEEF, 32'h0, 1'b0, 0);
        chk("dm_wr_running_wen", dm_wen_cnt - dm0, 32'd1);
        chk("dm_wr_addr", {21'd0, ahb_dm_addr}, 32'd2);

        // BUSY transfer with hsel high: no activity.
        hsel = 1'b1; htrans = 2'b01; haddr = 32'h0000_4010; hwrite = 1'b1;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h5555_5555;
        @(negedge clk);
        chk("busy_no_wen", {31'd0, ahb_dm_wen}, 32'd0);
        chk("busy_ready", {31'd0, hreadyout}, 32'd1);
        @(posedge clk); #1;

        // Back-to-back: write DM word 7, read it in the WR cycle.
        sb_q.push_back('{32'hCAFE_0007, 1'b0, 1, 1'b1});
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_401C; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        hwdata = 32'hCAFE_0007; hwrite = 1'b0;
        @(negedge clk);
        chk("b2b_wr_wen", {31'd0, ahb_dm_wen}, 32'd1);
        chk("b2b_wr_addr", {21'd0, ahb_dm_addr}, 32'd7);
        chk("b2b_wr_din", ahb_dm_din, 32'hCAFE_0007);
        chk("b2b_wr_ready", {31'd0, hreadyout}, 32'd1);
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; haddr = '0;
        @(negedge clk);
        chk("b2b_rd_wait", {31'd0, hreadyout}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk("b2b_sb_empty", 32'd1, 32'd0);
        end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("b2b_rdata", hrdata, e.rdata);
            chk("b2b_rd_ready", {31'd0, hreadyout}, 32'd1);
            chk("b2b_resp", {31'd0, hresp}, {31'd0, e.resp});
        end
        @(posedge clk); #1;

        // Reset asserted during RD_WAIT.
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_0014; hwrite = 1'b0; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; haddr = '0;
        #2;
        chk("mid_rd_wait", {31'd0, hreadyout}, 32'd0);
        chk("mid_cpu_rstn_hi", {31'd0, cpu_rstn}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("arst_hreadyout", {31'd0, hreadyout}, 32'd1);
        chk("arst_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
        chk("arst_hrdata", hrdata, 32'd0);
        chk("arst_im_addr", {21'd0, ahb_im_addr}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        sb_xfer("post_rst_im", 32'h0000_0014, 1'b0, 3'b010, 32'h0, 32'h1234_5678, 1'b0, 1);
        sb_xfer("post_rst_run", 32'h0000_C000, 1'b0, 3'b010, 32'h0, 32'd0, 1'b0, 1);
        sb_xfer("post_rst_cyc", 32'h0000_C004, 1'b0, 3'b010, 32'h0, 32'd0, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_dbg_ahb_bridge.md
# cpu_dbg_ahb_bridge

AHB-Lite slave that sits directly upstream of the pipelined CPU top level and is the only driver of its debug/loader ports (instruction memory, data memory and register-file peek). It turns 32-bit word bus transfers into `ahb_im_*` / `ahb_dm_*` / `ahb_rf_*` accesses. It also owns a run-control register that holds the CPU in reset while software is loaded, and a free-running cycle counter for benchmarking.

## Interface
Parameters:
- IM_AW, 11, instruction-memory word-address width
- DM_AW, 11, data-memory word-address width

Ports:
- Clock and reset: single clock `clk`; asynchronous active-low reset `rstn`.
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- haddr  in  32  byte address; [15:14] region, [1:0] must be 0
- htrans  in  2  AHB transfer type; only NONSEQ/SEQ (bit1=1) start transfers
- hwrite  in  1  1 = write
- hsize  in  3  must be 3'b010 (word)
- hwdata  in  32  write data (data phase)
- hready  in  1  bus-wide ready
- hreadyout  out  1  slave ready
- hresp  out  1  1 = ERROR
- hrdata  out  32  read data
- cpu_rstn  out  1  registered active-low reset to the CPU core
- ahb_rf_addr  out  5  register-file peek address
- ahb_rf_data  in  32  register-file peek data
- ahb_im_addr  out  IM_AW  IM word address
- ahb_im_din  out  32  IM write data
- ahb_im_wen  out  1  IM write enable
- ahb_im_dout  in  32  IM read data, valid one cycle after address
- ahb_dm_addr, ahb_dm_din, ahb_dm_wen, ahb_dm_dout: same as IM, with DM_AW

## Operation
- Address map by haddr[15:14]:
  - 00: IM, word index haddr[IM_AW+1:2].
  - 01: DM, word index haddr[DM_AW+1:2].
  - 10: RF, index haddr[6:2]; read-only.
  - 11: CTRL.
- CTRL registers:
  - Offset 0x0 RUN: bit0 read/write; other bits read 0.
  - Offset 0x4 CYCLES: read-only.
  - Any other CTRL offset is an error.
- Address phase is accepted when hsel & htrans[1] & hready. Accepting it registers region, index, hwrite and the error decision.
- Error conditions:
  - hsize != 010
  - haddr[1:0] != 0
  - write to RF
  - write to CYCLES
  - write to IM while RUN=1
  - unmapped CTRL offset
- An errored transfer causes no side effect on any memory, RF or CTRL register.
- FSM states: IDLE, WR, RD_WAIT, RD_DATA, ERR1, ERR2.
  - From IDLE/WR/RD_DATA/ERR2 on an accepted phase: error → ERR1; write → WR; read → RD_WAIT. With no accepted phase → IDLE.
  - RD_WAIT → RD_DATA.
  - ERR1 → ERR2.
- cpu_rstn is the registered value of RUN.
- CYCLES behaviour:
  - Increments by 1 each clk while RUN=1; holds while RUN=0.
  - Clears to 0 on the cycle a write sets RUN 0→1.
  - Wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - hreadyout=1, hresp=0, hrdata=0.
  - cpu_rstn=0, RUN=0, CYCLES=0.
  - All addr/din outputs 0; both wen=0; FSM=IDLE.
- Write (WR, one cycle, zero wait):
  - Registered index drives ahb_x_addr; ahb_x_din=hwdata.
  - ahb_x_wen=1 for exactly this cycle.
  - hreadyout=1, hresp=0.
  - A CTRL write updates RUN at the end of the WR cycle; cpu_rstn follows one cycle later.
- Read (one wait state):
  - RD_WAIT: registered index drives ahb_x_addr / ahb_rf_addr; hreadyout=0.
  - RD_DATA: hrdata is taken from a registered capture (end of RD_WAIT) of ahb_x_dout / ahb_rf_data / CTRL value; hreadyout=1.
  - Read latency from address phase to data = 2 cycles.
- Error response: ERR1 hresp=1, hreadyout=0; ERR2 hresp=1, hreadyout=1.
- hrdata holds its last value outside RD_DATA; addr outputs hold their last value.
- Back-to-back: a new address phase is accepted in the same cycle as the final data-phase cycle (hreadyout=1).
- Write followed immediately by a read of the same word returns the new data: the memory write completes before RD_WAIT.
- Reset asserted mid-transfer: all state returns to reset values asynchronously; wen drops immediately; the transfer is abandoned.
- Accepted transfers with hsel=0 or htrans=IDLE/BUSY produce no activity; the FSM goes to IDLE.

## Test plan
- Reset, then write 0x12345678 to IM word 5 (haddr 0x0014), then read it back → ahb_im_wen high for 1 cycle with addr 5; read shows hreadyout low 1 cycle, then hrdata=0x12345678, hresp=0.
- Write 0x1 to RUN (haddr 0xC000), idle 10 cycles, read CYCLES → cpu_rstn rises 1 cycle after WR; CYCLES in the 10–12 range, exact value per Timing rules.
- With RUN=1, write to IM word 0 → hresp ERR1/ERR2 pattern, ahb_im_wen never asserted; DM write at 0x4008 succeeds (ahb_dm_addr=2).
- Read RF index 31 (haddr 0x807C) with ahb_rf_data=0xDEADBEEF → ahb_rf_addr=31, hrdata=0xDEADBEEF; write to 0x807C → ERROR.
- Byte-size read (hsize=000) and misaligned haddr 0x0002 → both ERROR; no memory access.
- Assert rstn low during RD_WAIT → hreadyout=1, cpu_rstn=0, RUN=0 immediately; first transfer after release completes normally.
